// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 104;
  localparam int DATA_BITS_DEFAULT    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Last baud-counter value of the first half bit; mid-bit sampling point.
  function automatic int half_bit_last(input int clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so that an idle line is never mistaken for a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ack hold register and framing/overrun
// pulses. Samples each bit at its centre using a per-state baud counter.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX,
  input  logic                 ACK,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 DATA_VALID,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY,
  output logic [3:0]           count_r
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit_last(CLKS_PER_BIT));
  localparam logic [3:0]       LAST_IDX  = 4'(DATA_BITS - 1);

  uart_state_t          state;
  uart_state_t          state_next;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_s;
  logic                 armed;
  logic                 bit_tick;
  logic                 stop_tick;
  logic                 load_byte;
  logic                 drop_byte;
  logic                 bad_stop;

  uart_rx_sync u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (RX),
    .q   (rx_s)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!rx_s && armed) state_next = START;
      START:   if (cnt == HALF_LAST) state_next = rx_s ? IDLE : DATA;
      DATA:    if (bit_tick && count_r == LAST_IDX) state_next = STOP;
      STOP:    if (stop_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A completing byte may reuse the holding register if the host acks in
  // that same cycle; otherwise it is dropped and reported as an overrun.
  always_comb begin
    BUSY      = (state != IDLE);
    bit_tick  = (state == DATA) && (cnt == BIT_LAST);
    stop_tick = (state == STOP) && (cnt == BIT_LAST);
    load_byte = stop_tick && rx_s && (!DATA_VALID || ACK);
    drop_byte = stop_tick && rx_s && DATA_VALID && !ACK;
    bad_stop  = stop_tick && !rx_s;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt        <= '0;
      count_r    <= '0;
      shift      <= '0;
      armed      <= 1'b1;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      if (state_next != state || state == IDLE || cnt == BIT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (state_next == IDLE || (state == START && state_next == DATA)) begin
        count_r <= '0;
      end else if (bit_tick) begin
        count_r <= count_r + 4'd1;
      end

      if (bit_tick) begin
        shift[count_r[IDX_W-1:0]] <= rx_s;
      end

      // After a break-like frame the line must go high before rearming.
      if (bad_stop) begin
        armed <= 1'b0;
      end else if (rx_s) begin
        armed <= 1'b1;
      end

      if (load_byte) begin
        DATA_OUT   <= shift;
        DATA_VALID <= 1'b1;
      end else if (ACK) begin
        DATA_VALID <= 1'b0;
      end

      FRAME_ERR <= bad_stop;
      OVERRUN   <= drop_byte;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// checked against a frame-level model of the holding register and flags.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 104;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [3:0] count_r;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  int busy_cnt = 0;
  int dv_rise_cycle = -1;
  int last_fall_cycle = 0;
  logic dv_prev = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .CLK        (clk),
    .RST        (rst),
    .RX         (rx),
    .ACK        (ack),
    .DATA_OUT   (data_out),
    .DATA_VALID (data_valid),
    .FRAME_ERR  (frame_err),
    .OVERRUN    (overrun),
    .BUSY       (busy),
    .count_r    (count_r)
  );

  always #41.667 clk = ~clk;

  always @(posedge clk) cycle++;

  // Pulse and edge monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
    if (busy) busy_cnt++;
    if (data_valid && !dv_prev) dv_rise_cycle = cycle;
    dv_prev = data_valid;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    last_fall_cycle = cycle;
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_cycles(CPB);
    end
    rx = stop_bit;
    wait_cycles(CPB);
    rx = 1'b1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    wait_cycles(1);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    wait_cycles(3);
    tests++;
    if ({data_out, data_valid, frame_err, overrun, busy, count_r} !== 16'h0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got out=%h v=%b fe=%b ov=%b busy=%b cnt=%0d, expected all zero",
               data_out, data_valid, frame_err, overrun, busy, count_r);
    end
    rst = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_glitch();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    int b0  = busy_cnt;
    rx = 1'b0;
    wait_cycles(20);
    rx = 1'b1;
    wait_cycles(CPB);
    tests++;
    if (!(busy_cnt > b0) || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL glitch_busy: busy cycles=%0d final busy=%b, expected >0 and 0", busy_cnt - b0, busy);
    end
    tests++;
    if (data_valid !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0) begin
      fails++;
      $display("[TB] FAIL glitch_flags: got v=%b fe=%0d ov=%0d, expected 0 0 0", data_valid, fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_frame_err();
    int fe0 = fe_cnt;
    applyStimulus(8'hA5, 1'b0);
    wait_cycles(20);
    tests++;
    if (fe_cnt - fe0 != 1) begin
      fails++;
      $display("[TB] FAIL frame_err_pulses: got %0d, expected 1", fe_cnt - fe0);
    end
    tests++;
    if (data_valid !== 1'b0 || data_out !== 8'h00) begin
      fails++;
      $display("[TB] FAIL frame_err_data: got v=%b out=%h, expected v=0 out=00", data_valid, data_out);
    end
  endtask

  task automatic test_loopback();
    int fe0 = fe_cnt;
    int lat;
    applyStimulus(8'hF0, 1'b1);
    wait_cycles(10);
    lat = dv_rise_cycle - last_fall_cycle;
    tests++;
    if (data_out !== 8'hF0 || data_valid !== 1'b1 || fe_cnt != fe0) begin
      fails++;
      $display("[TB] FAIL loopback_F0: got out=%h v=%b fe=%0d, expected out=f0 v=1 fe=0", data_out, data_valid, fe_cnt - fe0);
    end
    tests++;
    if (lat < 988 || lat > 992) begin
      fails++;
      $display("[TB] FAIL loopback_latency: got %0d cycles, expected 988..992", lat);
    end
    pulse_ack();
    tests++;
    if (data_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ack_clears: got v=%b, expected 0", data_valid);
    end
    pulse_ack();
    tests++;
    if (data_valid !== 1'b0 || data_out !== 8'hF0) begin
      fails++;
      $display("[TB] FAIL ack_idle_ignored: got v=%b out=%h, expected v=0 out=f0", data_valid, data_out);
    end
  endtask

  task automatic test_back_to_back();
    int ov0 = ov_cnt;
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'hAA, 1'b1);
    wait_cycles(10);
    tests++;
    if (data_out !== 8'h55 || data_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_data: got out=%h v=%b, expected out=55 v=1", data_out, data_valid);
    end
    tests++;
    if (ov_cnt - ov0 != 1) begin
      fails++;
      $display("[TB] FAIL b2b_overrun: got %0d pulses, expected 1", ov_cnt - ov0);
    end
    pulse_ack();
    tests++;
    if (data_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_ack: got v=%b, expected 0", data_valid);
    end
  endtask

  // Completion edge: 2 sync edges + 1 idle detect + CPB/2 + 9*CPB after the
  // start-bit drive, i.e. 991 edges for CPB=104; ACK is high only on that one.
  task automatic test_ack_same_cycle();
    int ov0;
    applyStimulus(8'h11, 1'b1);
    wait_cycles(10);
    tests++;
    if (data_out !== 8'h11 || data_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL hold_11: got out=%h v=%b, expected out=11 v=1", data_out, data_valid);
    end
    ov0 = ov_cnt;
    fork
      applyStimulus(8'h3C, 1'b1);
      begin
        wait_cycles(3 + CPB / 2 + 9 * CPB - 1);
        ack = 1'b1;
        wait_cycles(1);
        ack = 1'b0;
      end
    join
    wait_cycles(10);
    tests++;
    if (data_out !== 8'h3C || data_valid !== 1'b1 || ov_cnt != ov0) begin
      fails++;
      $display("[TB] FAIL ack_same_cycle: got out=%h v=%b ov=%0d, expected out=3c v=1 ov=0",
               data_out, data_valid, ov_cnt - ov0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] partial = 8'h5A;
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      wait_cycles(CPB);
    end
    rx = partial[4];
    wait_cycles(CPB / 2);
    rx = 1'b1;
    rst = 1'b1;
    wait_cycles(1);
    tests++;
    if ({data_out, data_valid, frame_err, overrun, busy, count_r} !== 16'h0) begin
      fails++;
      $display("[TB] FAIL mid_reset_outputs: got out=%h v=%b fe=%b ov=%b busy=%b cnt=%0d, expected all zero",
               data_out, data_valid, frame_err, overrun, busy, count_r);
    end
    rst = 1'b0;
    wait_cycles(CPB);
    tests++;
    if (fe_cnt != fe0 || ov_cnt != ov0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_reset_silent: got fe=%0d ov=%0d busy=%b, expected 0 0 0", fe_cnt - fe0, ov_cnt - ov0, busy);
    end
    applyStimulus(8'hC3, 1'b1);
    wait_cycles(10);
    tests++;
    if (data_out !== 8'hC3 || data_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL after_reset_C3: got out=%h v=%b, expected out=c3 v=1", data_out, data_valid);
    end
    pulse_ack();
  endtask

  task automatic test_random_frames();
    logic [7:0] model_out = 8'hC3;
    logic       model_valid = 1'b0;
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b = 8'($urandom);
      logic good = ($urandom_range(0, 3) != 0);
      int fe0, ov0, exp_fe, exp_ov;
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        model_valid = 1'b0;
      end
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      exp_fe = 0;
      exp_ov = 0;
      applyStimulus(b, good);
      wait_cycles(10 + $urandom_range(0, 30));
      if (!good) exp_fe = 1;
      else if (model_valid) exp_ov = 1;
      else begin
        model_out = b;
        model_valid = 1'b1;
      end
      tests++;
      if (data_out !== model_out || data_valid !== model_valid) begin
        fails++;
        $display("[TB] FAIL rand_%0d_data: got out=%h v=%b, expected out=%h v=%b",
                 n, data_out, data_valid, model_out, model_valid);
      end
      tests++;
      if (fe_cnt - fe0 != exp_fe || ov_cnt - ov0 != exp_ov) begin
        fails++;
        $display("[TB] FAIL rand_%0d_flags: got fe=%0d ov=%0d, expected fe=%0d ov=%0d",
                 n, fe_cnt - fe0, ov_cnt - ov0, exp_fe, exp_ov);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    test_reset();
    test_glitch();
    test_frame_err();
    test_loopback();
    test_back_to_back();
    test_ack_same_cycle();
    test_reset_mid_frame();
    test_random_frames();
    tests++;
    if (both_cnt != 0) begin
      fails++;
      $display("[TB] FAIL flags_exclusive: got %0d cycles with both pulses, expected 0", both_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
